// File: rtl/paquete_ud.sv
// Shared definitions for the program counter: datapath width and the resolved
// per-cycle operation that both the PC and its return stack act on.
package paquete_ud;

    localparam int ANCHO_PALABRA = 16;

    typedef enum logic [2:0] {
        OP_NADA,
        OP_INC,
        OP_CARGA,
        OP_LLAMADA,
        OP_RETORNO
    } operacion_t;

    // Strobe priority: return beats call, call beats jump, jump beats increment.
    function automatic operacion_t resolver(
        input logic retornar,
        input logic llamar,
        input logic cargar,
        input logic incrementar
    );
        if (retornar)         return OP_RETORNO;
        else if (llamar)      return OP_LLAMADA;
        else if (cargar)      return OP_CARGA;
        else if (incrementar) return OP_INC;
        else                  return OP_NADA;
    endfunction

endpackage

// File: rtl/pila_retorno.sv
// Hardware return-address LIFO. Refuses a push when full and a pop when empty,
// and reports each refused request for one cycle so the caller can flag it.
module pila_retorno
    import paquete_ud::*;
#(
    parameter int ANCHO       = ANCHO_PALABRA,
    parameter int PROFUNDIDAD = 4,
    localparam int IW         = $clog2(PROFUNDIDAD),
    localparam int NW         = IW + 1
) (
    input  logic             Reloj,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [ANCHO-1:0] dato,
    output logic [ANCHO-1:0] tope,
    output logic [NW-1:0]    nivel,
    output logic             llena,
    output logic             vacia,
    output logic             desborde,
    output logic             subdesborde
);

    logic [ANCHO-1:0] memoria [PROFUNDIDAD];
    logic [IW-1:0]    indice_push;
    logic [IW-1:0]    indice_tope;

    assign llena       = (nivel == NW'(PROFUNDIDAD));
    assign vacia       = (nivel == '0);
    assign desborde    = push & llena;
    assign subdesborde = pop & vacia;

    // Indices are only meaningful when not full (push) or not empty (pop).
    assign indice_push = IW'(nivel);
    assign indice_tope = IW'(nivel - NW'(1));
    assign tope        = memoria[indice_tope];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            nivel <= '0;
        end else if (push && !llena) begin
            nivel <= nivel + NW'(1);
        end else if (pop && !vacia) begin
            nivel <= nivel - NW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; an empty level makes
    // its contents unreachable, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge Reloj) begin
        if (push && !llena) begin
            memoria[indice_push] <= dato;
        end
    end

endmodule

// File: rtl/contador_programa_pila.sv
// 16-bit program counter with a return stack: increment, jump, call and return,
// with a sticky error flag for stack overflow or underflow.
module contador_programa_pila
    import paquete_ud::*;
#(
    parameter int                  ANCHO        = ANCHO_PALABRA,
    parameter int                  PROFUNDIDAD  = 4,
    parameter logic [ANCHO-1:0]    VECTOR_RESET = '0,
    parameter int                  INCREMENTO   = 1,
    localparam int                 NW           = $clog2(PROFUNDIDAD) + 1
) (
    input  logic             Reloj,
    input  logic             Reset_n,
    input  logic             Habilitar,
    input  logic [ANCHO-1:0] Entrada,
    input  logic             Incrementar,
    input  logic             Cargar,
    input  logic             Llamar,
    input  logic             Retornar,
    output logic [ANCHO-1:0] Salida,
    output logic [NW-1:0]    Nivel,
    output logic             PilaVacia,
    output logic             PilaLlena,
    output logic             Error
);

    localparam logic [ANCHO-1:0] PASO = ANCHO'(INCREMENTO);

    operacion_t       op;
    logic [ANCHO-1:0] siguiente;
    logic [ANCHO-1:0] tope;
    logic             desborde;
    logic             subdesborde;

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        op = OP_NADA;
        if (Habilitar) begin
            op = resolver(Retornar, Llamar, Cargar, Incrementar);
        end
    end

    // Wraps modulo 2^ANCHO; also the return address pushed by a call.
    assign siguiente = Salida + PASO;

    pila_retorno #(
        .ANCHO       (ANCHO),
        .PROFUNDIDAD (PROFUNDIDAD)
    ) u_pila (
        .Reloj       (Reloj),
        .Reset_n     (Reset_n),
        .push        (op == OP_LLAMADA),
        .pop         (op == OP_RETORNO),
        .dato        (siguiente),
        .tope        (tope),
        .nivel       (Nivel),
        .llena       (PilaLlena),
        .vacia       (PilaVacia),
        .desborde    (desborde),
        .subdesborde (subdesborde)
    );

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            Salida <= VECTOR_RESET;
            Error  <= 1'b0;
        end else begin
            unique case (op)
                OP_INC:   Salida <= siguiente;
                OP_CARGA: Salida <= Entrada;
                OP_LLAMADA: begin
                    if (desborde) Error  <= 1'b1;
                    else          Salida <= Entrada;
                end
                OP_RETORNO: begin
                    if (subdesborde) Error  <= 1'b1;
                    else             Salida <= tope;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_programa_pila.sv
// Self-checking bench: directed scenarios followed by random strobes, compared
// every cycle against a queue-based model of the program counter.
module tb_contador_programa_pila;
    import paquete_ud::*;

    localparam logic [15:0] VR = 16'h0000;

    logic        Reloj = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Habilitar = 1'b0;
    logic [15:0] Entrada = '0;
    logic        Incrementar = 1'b0;
    logic        Cargar = 1'b0;
    logic        Llamar = 1'b0;
    logic        Retornar = 1'b0;
    logic [15:0] Salida;
    logic [2:0]  Nivel;
    logic        PilaVacia;
    logic        PilaLlena;
    logic        Error;

    int comparados = 0;
    int fallos     = 0;

    // Reference model state
    logic [15:0] m_pc  = VR;
    logic [15:0] m_pila[$];
    bit          m_err = 1'b0;

    contador_programa_pila dut (
        .Reloj       (Reloj),
        .Reset_n     (Reset_n),
        .Habilitar   (Habilitar),
        .Entrada     (Entrada),
        .Incrementar (Incrementar),
        .Cargar      (Cargar),
        .Llamar      (Llamar),
        .Retornar    (Retornar),
        .Salida      (Salida),
        .Nivel       (Nivel),
        .PilaVacia   (PilaVacia),
        .PilaLlena   (PilaLlena),
        .Error       (Error)
    );

    always #5 Reloj = ~Reloj;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comparados++;
        assert (obs === exp) else begin
            fallos++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " Salida"},    32'(Salida),    32'(m_pc));
        check({tag, " Nivel"},     32'(Nivel),     32'(m_pila.size()));
        check({tag, " PilaVacia"}, 32'(PilaVacia), 32'(m_pila.size() == 0));
        check({tag, " PilaLlena"}, 32'(PilaLlena), 32'(m_pila.size() == 4));
        check({tag, " Error"},     32'(Error),     32'(m_err));
    endtask

    task automatic modelo(input bit hab, input bit inc, input bit car,
                          input bit lla, input bit ret, input logic [15:0] ent);
        operacion_t op;
        if (!hab)     op = OP_NADA;
        else if (ret) op = OP_RETORNO;
        else if (lla) op = OP_LLAMADA;
        else if (car) op = OP_CARGA;
        else if (inc) op = OP_INC;
        else          op = OP_NADA;
        case (op)
            OP_INC:   m_pc = m_pc + 16'd1;
            OP_CARGA: m_pc = ent;
            OP_LLAMADA: begin
                if (m_pila.size() < 4) begin
                    m_pila.push_back(m_pc + 16'd1);
                    m_pc = ent;
                end else begin
                    m_err = 1'b1;
                end
            end
            OP_RETORNO: begin
                if (m_pila.size() > 0) m_pc = m_pila.pop_back();
                else                   m_err = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic paso(input string tag, input bit hab, input bit inc, input bit car,
                        input bit lla, input bit ret, input logic [15:0] ent);
        Habilitar = hab; Incrementar = inc; Cargar = car;
        Llamar = lla; Retornar = ret; Entrada = ent;
        @(posedge Reloj);
        #1;
        modelo(hab, inc, car, lla, ret, ent);
        check_all(tag);
    endtask

    // Asserts reset away from any clock edge and checks the immediate effect.
    task automatic pulso_reset(input string tag);
        #2;
        Reset_n = 1'b0;
        #1;
        m_pc = VR;
        m_pila.delete();
        m_err = 1'b0;
        check_all({tag, " async"});
        @(posedge Reloj);
        #1;
        Reset_n = 1'b1;
        Habilitar = 1'b0; Incrementar = 1'b0; Cargar = 1'b0;
        Llamar = 1'b0; Retornar = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        m_pila.delete();
        check_all("reset");
        @(posedge Reloj);
        #1;
        Reset_n = 1'b1;

        // Three increments from the reset vector
        for (int i = 0; i < 3; i++) paso("inc", 1, 1, 0, 0, 0, 16'h0);
        check("inc Salida const", 32'(Salida), 32'h0003);

        // Jump near the top of the address space, then wrap
        paso("carga FFFE", 1, 0, 1, 0, 0, 16'hFFFE);
        paso("inc FFFF",   1, 1, 0, 0, 0, 16'h0);
        paso("inc wrap",   1, 1, 0, 0, 0, 16'h0);
        check("wrap Salida const", 32'(Salida), 32'h0000);

        // Nested call/return from 0010
        paso("carga 0010", 1, 0, 1, 0, 0, 16'h0010);
        paso("call 0200",  1, 0, 0, 1, 0, 16'h0200);
        paso("call 0300",  1, 0, 0, 1, 0, 16'h0300);
        paso("ret 1",      1, 0, 0, 0, 1, 16'h0);
        check("ret1 Salida const", 32'(Salida), 32'h0201);
        paso("ret 2",      1, 0, 0, 0, 1, 16'h0);
        check("ret2 Salida const", 32'(Salida), 32'h0011);

        // Overflow: five calls from 0000 on an empty stack
        pulso_reset("rst ovf");
        for (int i = 0; i < 5; i++) paso("call ovf", 1, 0, 0, 1, 0, 16'h1000 + 16'(i));
        check("ovf Salida const", 32'(Salida), 32'h1003);
        check("ovf Error const",  32'(Error),  32'h1);
        for (int i = 0; i < 4; i++) paso("ret ovf", 1, 0, 0, 0, 1, 16'h0);
        check("ovf unwind const", 32'(Salida), 32'h0001);

        // Underflow, then Error stays sticky through a jump until reset
        pulso_reset("rst udf");
        paso("carga 0040", 1, 0, 1, 0, 0, 16'h0040);
        paso("ret udf",    1, 0, 0, 0, 1, 16'h0);
        paso("carga 0050", 1, 0, 1, 0, 0, 16'h0050);
        check("sticky Error const", 32'(Error), 32'h1);
        pulso_reset("rst clear");

        // Priority with one entry on the stack, then freeze with everything asserted
        paso("call 0700",  1, 0, 0, 1, 0, 16'h0700);
        paso("prio",       1, 1, 1, 1, 1, 16'h0900);
        paso("call 0A00",  1, 0, 0, 1, 0, 16'h0A00);
        paso("freeze",     0, 1, 1, 1, 1, 16'h0B00);
        paso("freeze 2",   0, 1, 1, 1, 1, 16'h0C00);

        // Random strobes with occasional freezes and mid-sequence resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulso_reset("rnd rst");
            end else begin
                paso("rnd",
                     $urandom_range(0, 9) != 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule
